// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI4 memory arbiter.
// The state set is IDLE/IFU_RD/LSU_RD/LSU_WR; grant codes line up with those state codes.
package axi_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_IFU_RD = 2'd1;
  localparam state_t ST_LSU_RD = 2'd2;
  localparam state_t ST_LSU_WR = 2'd3;

  // Each grant code equals the state it leads to, so IDLE can load the grant directly.
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_IFU    = 2'd1,
    GNT_LSU_RD = 2'd2,
    GNT_LSU_WR = 2'd3
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic state_t grant_to_state(input grant_e g);
    return state_t'(g);
  endfunction

endpackage

// File: rtl/axi_arb_pick.sv
// Request-to-grant selector: LSU write first, then LSU read vs IFU.
// With ARB_RR_EN defined, LSU-read/IFU ties alternate via a last_grant bit.
module axi_arb_pick
  import axi_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
`endif
  input  logic   ifu_req,
  input  logic   lsu_rd_req,
  input  logic   lsu_wr_req,
  output grant_e grant
);

  logic lsu_wins_tie;

`ifdef ARB_RR_EN
  logic last_lsu;  // 0: IFU was the last read grant, 1: LSU was

  assign lsu_wins_tie = ~last_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu <= 1'b0;
    end else if (grant_en && (grant == GNT_LSU_RD || grant == GNT_IFU)) begin
      last_lsu <= (grant == GNT_LSU_RD);
    end
  end
`else
  assign lsu_wins_tie = 1'b1;
`endif

  // NOTE: assign the output a default first so no path through the block can infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (lsu_wr_req) begin
      grant = GNT_LSU_WR;
    end else if (lsu_rd_req && (lsu_wins_tie || !ifu_req)) begin
      grant = GNT_LSU_RD;
    end else if (ifu_req) begin
      grant = GNT_IFU;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 master port between IFU (read-only) and LSU (read/write), one transaction at a time.
// Define ARB_RR_EN for round-robin LSU-read/IFU tie-breaking; fixed priority otherwise.
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  // IFU
  input  logic                i_ifu_arvalid,
  output logic                o_ifu_arready,
  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  input  logic [ID_W-1:0]     i_ifu_arid,
  input  logic [7:0]          i_ifu_arlen,
  input  logic [2:0]          i_ifu_arsize,
  input  logic [1:0]          i_ifu_arburst,
  output logic                o_ifu_rvalid,
  input  logic                i_ifu_rready,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  output logic                o_ifu_rlast,
  output logic [ID_W-1:0]     o_ifu_rid,
  // LSU
  input  logic                i_lsu_arvalid,
  output logic                o_lsu_arready,
  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  input  logic [ID_W-1:0]     i_lsu_arid,
  input  logic [7:0]          i_lsu_arlen,
  input  logic [2:0]          i_lsu_arsize,
  input  logic [1:0]          i_lsu_arburst,
  output logic                o_lsu_rvalid,
  input  logic                i_lsu_rready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  output logic                o_lsu_rlast,
  output logic [ID_W-1:0]     o_lsu_rid,
  input  logic                i_lsu_awvalid,
  output logic                o_lsu_awready,
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  input  logic [ID_W-1:0]     i_lsu_awid,
  input  logic [7:0]          i_lsu_awlen,
  input  logic [2:0]          i_lsu_awsize,
  input  logic [1:0]          i_lsu_awburst,
  input  logic                i_lsu_wvalid,
  output logic                o_lsu_wready,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic                i_lsu_wlast,
  output logic                o_lsu_bvalid,
  input  logic                i_lsu_bready,
  output logic [1:0]          o_lsu_bresp,
  output logic [ID_W-1:0]     o_lsu_bid,
  // Downstream
  output logic                o_axi_arvalid,
  input  logic                i_axi_arready,
  output logic [ADDR_W-1:0]   o_axi_araddr,
  output logic [ID_W-1:0]     o_axi_arid,
  output logic [7:0]          o_axi_arlen,
  output logic [2:0]          o_axi_arsize,
  output logic [1:0]          o_axi_arburst,
  output logic                o_axi_awvalid,
  input  logic                i_axi_awready,
  output logic [ADDR_W-1:0]   o_axi_awaddr,
  output logic [ID_W-1:0]     o_axi_awid,
  output logic [7:0]          o_axi_awlen,
  output logic [2:0]          o_axi_awsize,
  output logic [1:0]          o_axi_awburst,
  output logic                o_axi_wvalid,
  input  logic                i_axi_wready,
  output logic [DATA_W-1:0]   o_axi_wdata,
  output logic [DATA_W/8-1:0] o_axi_wstrb,
  output logic                o_axi_wlast,
  input  logic                i_axi_rvalid,
  output logic                o_axi_rready,
  input  logic [DATA_W-1:0]   i_axi_rdata,
  input  logic [1:0]          i_axi_rresp,
  input  logic                i_axi_rlast,
  input  logic [ID_W-1:0]     i_axi_rid,
  input  logic                i_axi_bvalid,
  output logic                o_axi_bready,
  input  logic [1:0]          i_axi_bresp,
  input  logic [ID_W-1:0]     i_axi_bid
);

  state_t state;
  logic   aw_done;
  logic   w_done;
  grant_e grant;

  logic rd_ifu, rd_lsu, in_wr;
  logic r_done, aw_hs, w_hs, b_hs;

  assign rd_ifu = (state == ST_IFU_RD);
  assign rd_lsu = (state == ST_LSU_RD);
  assign in_wr  = (state == ST_LSU_WR);

  axi_arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk        (i_clock),
    .rst        (i_reset),
    .grant_en   (state == ST_IDLE),
`endif
    .ifu_req    (i_ifu_arvalid),
    .lsu_rd_req (i_lsu_arvalid),
    .lsu_wr_req (i_lsu_awvalid | i_lsu_wvalid),
    .grant      (grant)
  );

  // AR channel: the granted requester's request goes downstream, the other sees arready=0.
  always_comb begin
    o_axi_arvalid = 1'b0;
    o_axi_araddr  = '0;
    o_axi_arid    = '0;
    o_axi_arlen   = '0;
    o_axi_arsize  = '0;
    o_axi_arburst = '0;
    o_ifu_arready = 1'b0;
    o_lsu_arready = 1'b0;
    case (state)
      ST_IFU_RD: begin
        o_axi_arvalid = i_ifu_arvalid;
        o_axi_araddr  = i_ifu_araddr;
        o_axi_arid    = i_ifu_arid;
        o_axi_arlen   = i_ifu_arlen;
        o_axi_arsize  = i_ifu_arsize;
        o_axi_arburst = i_ifu_arburst;
        o_ifu_arready = i_axi_arready;
      end
      ST_LSU_RD: begin
        o_axi_arvalid = i_lsu_arvalid;
        o_axi_araddr  = i_lsu_araddr;
        o_axi_arid    = i_lsu_arid;
        o_axi_arlen   = i_lsu_arlen;
        o_axi_arsize  = i_lsu_arsize;
        o_axi_arburst = i_lsu_arburst;
        o_lsu_arready = i_axi_arready;
      end
      default: ;
    endcase
  end

  // R channel: a response outside the read window is left unacknowledged.
  assign o_axi_rready = rd_ifu ? i_ifu_rready : (rd_lsu ? i_lsu_rready : 1'b0);

  assign o_ifu_rvalid = rd_ifu & i_axi_rvalid;
  assign o_ifu_rdata  = rd_ifu ? i_axi_rdata : '0;
  assign o_ifu_rresp  = rd_ifu ? i_axi_rresp : '0;
  assign o_ifu_rlast  = rd_ifu & i_axi_rlast;
  assign o_ifu_rid    = rd_ifu ? i_axi_rid   : '0;

  assign o_lsu_rvalid = rd_lsu & i_axi_rvalid;
  assign o_lsu_rdata  = rd_lsu ? i_axi_rdata : '0;
  assign o_lsu_rresp  = rd_lsu ? i_axi_rresp : '0;
  assign o_lsu_rlast  = rd_lsu & i_axi_rlast;
  assign o_lsu_rid    = rd_lsu ? i_axi_rid   : '0;

  // AW and W run independently; each is masked once its handshake has completed.
  assign o_axi_awvalid = in_wr & i_lsu_awvalid & ~aw_done;
  assign o_lsu_awready = in_wr & i_axi_awready & ~aw_done;
  assign o_axi_awaddr  = in_wr ? i_lsu_awaddr  : '0;
  assign o_axi_awid    = in_wr ? i_lsu_awid    : '0;
  assign o_axi_awlen   = in_wr ? i_lsu_awlen   : '0;
  assign o_axi_awsize  = in_wr ? i_lsu_awsize  : '0;
  assign o_axi_awburst = in_wr ? i_lsu_awburst : '0;

  assign o_axi_wvalid = in_wr & i_lsu_wvalid & ~w_done;
  assign o_lsu_wready = in_wr & i_axi_wready & ~w_done;
  assign o_axi_wdata  = in_wr ? i_lsu_wdata : '0;
  assign o_axi_wstrb  = in_wr ? i_lsu_wstrb : '0;
  assign o_axi_wlast  = in_wr & i_lsu_wlast;

  assign o_lsu_bvalid = in_wr & i_axi_bvalid;
  assign o_axi_bready = in_wr & i_lsu_bready;
  assign o_lsu_bresp  = in_wr ? i_axi_bresp : '0;
  assign o_lsu_bid    = in_wr ? i_axi_bid   : '0;

  assign r_done = i_axi_rvalid & o_axi_rready & i_axi_rlast;
  assign aw_hs  = o_axi_awvalid & i_axi_awready;
  assign w_hs   = o_axi_wvalid & i_axi_wready;
  assign b_hs   = i_axi_bvalid & o_axi_bready;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= grant_to_state(grant);
        ST_IFU_RD, ST_LSU_RD: begin
          if (r_done) state <= ST_IDLE;
        end
        ST_LSU_WR: begin
          if (b_hs) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs)                w_done  <= w_done;
            if (aw_hs)                aw_done <= 1'b1;
            if (w_hs && i_lsu_wlast)  w_done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: stimulus pushes expected beats, a negedge monitor pops and compares.
// Expected grant order follows ARB_RR_EN when it is defined for the build.
module tb_axi_mem_arbiter;
  import axi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  always #5 clk = ~clk;

  logic        i_ifu_arvalid, o_ifu_arready;
  logic [31:0] i_ifu_araddr;
  logic [3:0]  i_ifu_arid;
  logic [7:0]  i_ifu_arlen;
  logic [2:0]  i_ifu_arsize;
  logic [1:0]  i_ifu_arburst;
  logic        o_ifu_rvalid, i_ifu_rready;
  logic [31:0] o_ifu_rdata;
  logic [1:0]  o_ifu_rresp;
  logic        o_ifu_rlast;
  logic [3:0]  o_ifu_rid;
  logic        i_lsu_arvalid, o_lsu_arready;
  logic [31:0] i_lsu_araddr;
  logic [3:0]  i_lsu_arid;
  logic [7:0]  i_lsu_arlen;
  logic [2:0]  i_lsu_arsize;
  logic [1:0]  i_lsu_arburst;
  logic        o_lsu_rvalid, i_lsu_rready;
  logic [31:0] o_lsu_rdata;
  logic [1:0]  o_lsu_rresp;
  logic        o_lsu_rlast;
  logic [3:0]  o_lsu_rid;
  logic        i_lsu_awvalid, o_lsu_awready;
  logic [31:0] i_lsu_awaddr;
  logic [3:0]  i_lsu_awid;
  logic [7:0]  i_lsu_awlen;
  logic [2:0]  i_lsu_awsize;
  logic [1:0]  i_lsu_awburst;
  logic        i_lsu_wvalid, o_lsu_wready;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wstrb;
  logic        i_lsu_wlast;
  logic        o_lsu_bvalid, i_lsu_bready;
  logic [1:0]  o_lsu_bresp;
  logic [3:0]  o_lsu_bid;
  logic        o_axi_arvalid, i_axi_arready;
  logic [31:0] o_axi_araddr;
  logic [3:0]  o_axi_arid;
  logic [7:0]  o_axi_arlen;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arburst;
  logic        o_axi_awvalid, i_axi_awready;
  logic [31:0] o_axi_awaddr;
  logic [3:0]  o_axi_awid;
  logic [7:0]  o_axi_awlen;
  logic [2:0]  o_axi_awsize;
  logic [1:0]  o_axi_awburst;
  logic        o_axi_wvalid, i_axi_wready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        o_axi_wlast;
  logic        i_axi_rvalid, o_axi_rready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic        i_axi_rlast;
  logic [3:0]  i_axi_rid;
  logic        i_axi_bvalid, o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic [3:0]  i_axi_bid;

  axi_mem_arbiter dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_ifu_arvalid(i_ifu_arvalid), .o_ifu_arready(o_ifu_arready), .i_ifu_araddr(i_ifu_araddr),
    .i_ifu_arid(i_ifu_arid), .i_ifu_arlen(i_ifu_arlen), .i_ifu_arsize(i_ifu_arsize),
    .i_ifu_arburst(i_ifu_arburst), .o_ifu_rvalid(o_ifu_rvalid), .i_ifu_rready(i_ifu_rready),
    .o_ifu_rdata(o_ifu_rdata), .o_ifu_rresp(o_ifu_rresp), .o_ifu_rlast(o_ifu_rlast), .o_ifu_rid(o_ifu_rid),
    .i_lsu_arvalid(i_lsu_arvalid), .o_lsu_arready(o_lsu_arready), .i_lsu_araddr(i_lsu_araddr),
    .i_lsu_arid(i_lsu_arid), .i_lsu_arlen(i_lsu_arlen), .i_lsu_arsize(i_lsu_arsize),
    .i_lsu_arburst(i_lsu_arburst), .o_lsu_rvalid(o_lsu_rvalid), .i_lsu_rready(i_lsu_rready),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_rresp(o_lsu_rresp), .o_lsu_rlast(o_lsu_rlast), .o_lsu_rid(o_lsu_rid),
    .i_lsu_awvalid(i_lsu_awvalid), .o_lsu_awready(o_lsu_awready), .i_lsu_awaddr(i_lsu_awaddr),
    .i_lsu_awid(i_lsu_awid), .i_lsu_awlen(i_lsu_awlen), .i_lsu_awsize(i_lsu_awsize),
    .i_lsu_awburst(i_lsu_awburst), .i_lsu_wvalid(i_lsu_wvalid), .o_lsu_wready(o_lsu_wready),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb), .i_lsu_wlast(i_lsu_wlast),
    .o_lsu_bvalid(o_lsu_bvalid), .i_lsu_bready(i_lsu_bready), .o_lsu_bresp(o_lsu_bresp), .o_lsu_bid(o_lsu_bid),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready), .o_axi_araddr(o_axi_araddr),
    .o_axi_arid(o_axi_arid), .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize),
    .o_axi_arburst(o_axi_arburst), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awid(o_axi_awid), .o_axi_awlen(o_axi_awlen),
    .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst), .o_axi_wvalid(o_axi_wvalid),
    .i_axi_wready(i_axi_wready), .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .o_axi_wlast(o_axi_wlast), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rlast(i_axi_rlast), .i_axi_rid(i_axi_rid),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp), .i_axi_bid(i_axi_bid)
  );

  typedef struct { logic [31:0] addr; logic [3:0] id; logic [7:0] len; } addr_t;
  typedef struct { logic [31:0] data; logic [3:0] id; logic [1:0] resp; logic last; } r_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } b_t;

  addr_t exp_ar[$], exp_aw[$];
  r_t    exp_ifu_r[$], exp_lsu_r[$];
  w_t    exp_w[$];
  b_t    exp_b[$];
  addr_t m_a;
  r_t    m_r;
  w_t    m_w;
  b_t    m_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pend_addr [2];
  logic [3:0]  pend_id   [2];
  logic [7:0]  pend_len  [2];
  bit          rr_last_lsu;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake the DUT presents must match the head of its expected queue.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_axi_arvalid && i_axi_arready) begin
        check("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          m_a = exp_ar.pop_front();
          check("ar_addr", o_axi_araddr, m_a.addr);
          check("ar_id", o_axi_arid, m_a.id);
          check("ar_len", o_axi_arlen, m_a.len);
          check("ar_size_burst", {o_axi_arsize, o_axi_arburst}, {3'd2, 2'b01});
        end
      end
      if (o_ifu_rvalid && i_ifu_rready) begin
        check("ifu_r_expected", exp_ifu_r.size() != 0, 1);
        if (exp_ifu_r.size() != 0) begin
          m_r = exp_ifu_r.pop_front();
          check("ifu_r_beat", {o_ifu_rdata, o_ifu_rid, o_ifu_rresp, o_ifu_rlast},
                {m_r.data, m_r.id, m_r.resp, m_r.last});
        end
      end
      if (o_lsu_rvalid && i_lsu_rready) begin
        check("lsu_r_expected", exp_lsu_r.size() != 0, 1);
        if (exp_lsu_r.size() != 0) begin
          m_r = exp_lsu_r.pop_front();
          check("lsu_r_beat", {o_lsu_rdata, o_lsu_rid, o_lsu_rresp, o_lsu_rlast},
                {m_r.data, m_r.id, m_r.resp, m_r.last});
        end
      end
      if (o_axi_awvalid && i_axi_awready) begin
        check("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          m_a = exp_aw.pop_front();
          check("aw_payload", {o_axi_awaddr, o_axi_awid, o_axi_awlen, o_axi_awsize, o_axi_awburst},
                {m_a.addr, m_a.id, m_a.len, 3'd2, 2'b01});
        end
      end
      if (o_axi_wvalid && i_axi_wready) begin
        check("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          m_w = exp_w.pop_front();
          check("w_payload", {o_axi_wdata, o_axi_wstrb, o_axi_wlast}, {m_w.data, m_w.strb, m_w.last});
        end
      end
      if (o_lsu_bvalid && i_lsu_bready) begin
        check("b_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          m_b = exp_b.pop_front();
          check("b_payload", {o_lsu_bresp, o_lsu_bid}, {m_b.resp, m_b.id});
        end
      end
    end
  end

  task automatic raise_ar(input bit lsu, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    pend_addr[lsu] = addr;
    pend_id[lsu]   = id;
    pend_len[lsu]  = len;
    if (lsu) begin
      i_lsu_arvalid = 1'b1; i_lsu_araddr = addr; i_lsu_arid = id; i_lsu_arlen = len;
      i_lsu_arsize = 3'd2; i_lsu_arburst = 2'b01;
    end else begin
      i_ifu_arvalid = 1'b1; i_ifu_araddr = addr; i_ifu_arid = id; i_ifu_arlen = len;
      i_ifu_arsize = 3'd2; i_ifu_arburst = 2'b01;
    end
  endtask

  // Called in IDLE with the request already raised; serves AR and nbeats R beats.
  task automatic serve_read(input bit lsu, input logic [31:0] base, input logic [1:0] resp, input int nbeats);
    addr_t a;
    r_t    r;
    check("ar_pre_grant", o_axi_arvalid, 0);
    tick();
    check("ar_latency", o_axi_arvalid, 1);
    a.addr = pend_addr[lsu]; a.id = pend_id[lsu]; a.len = pend_len[lsu];
    exp_ar.push_back(a);
    i_axi_arready = 1'b1;
    #1;
    if (lsu) check("ifu_arready_blocked", o_ifu_arready, 0);
    else     check("lsu_arready_blocked", o_lsu_arready, 0);
    tick();
    i_axi_arready = 1'b0;
    if (lsu) i_lsu_arvalid = 1'b0;
    else     i_ifu_arvalid = 1'b0;
    rr_last_lsu = lsu;
    for (int i = 0; i < nbeats; i++) begin
      r.data = base + 32'(i); r.id = pend_id[lsu]; r.resp = resp; r.last = (i == int'(pend_len[lsu]));
      i_axi_rvalid = 1'b1; i_axi_rdata = r.data; i_axi_rid = r.id; i_axi_rresp = r.resp; i_axi_rlast = r.last;
      if (lsu) exp_lsu_r.push_back(r);
      else     exp_ifu_r.push_back(r);
      #1;
      check("rready_routed", o_axi_rready, 1);
      check("ar_no_leak", o_axi_arvalid, 0);
      tick();
    end
    i_axi_rvalid = 1'b0;
    i_axi_rlast  = 1'b0;
    if (nbeats == int'(pend_len[lsu]) + 1) begin
      check("rd_idle", dut.state, ST_IDLE);
      check("idle_gap", o_axi_arvalid, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit    winner;
  addr_t wa;
  w_t    ww;
  b_t    wb;

  initial begin
    i_reset = 1'b1;
    i_ifu_arvalid = 0; i_ifu_araddr = 0; i_ifu_arid = 0; i_ifu_arlen = 0; i_ifu_arsize = 0; i_ifu_arburst = 0;
    i_lsu_arvalid = 0; i_lsu_araddr = 0; i_lsu_arid = 0; i_lsu_arlen = 0; i_lsu_arsize = 0; i_lsu_arburst = 0;
    i_lsu_awvalid = 0; i_lsu_awaddr = 0; i_lsu_awid = 0; i_lsu_awlen = 0; i_lsu_awsize = 0; i_lsu_awburst = 0;
    i_lsu_wvalid = 0; i_lsu_wdata = 0; i_lsu_wstrb = 0; i_lsu_wlast = 0;
    i_ifu_rready = 1; i_lsu_rready = 1; i_lsu_bready = 1;
    i_axi_arready = 0; i_axi_awready = 0; i_axi_wready = 0;
    i_axi_rvalid = 0; i_axi_rdata = 0; i_axi_rresp = 0; i_axi_rlast = 0; i_axi_rid = 0;
    i_axi_bvalid = 0; i_axi_bresp = 0; i_axi_bid = 0;
    rr_last_lsu = 1'b0;

    // Reset state with active-looking inputs present
    i_ifu_arvalid = 1; i_ifu_araddr = 32'h1234_5678; i_axi_arready = 1; i_axi_rvalid = 1; i_axi_bvalid = 1;
    i_lsu_awvalid = 1; i_axi_awready = 1;
    tick(); tick();
    check("rst_state", dut.state, ST_IDLE);
    check("rst_flags", {dut.aw_done, dut.w_done}, 2'b00);
    check("rst_valids", {o_axi_arvalid, o_axi_awvalid, o_axi_wvalid, o_ifu_rvalid, o_lsu_rvalid, o_lsu_bvalid}, 6'b0);
    check("rst_readies", {o_axi_rready, o_axi_bready, o_ifu_arready, o_lsu_arready, o_lsu_awready, o_lsu_wready}, 6'b0);
    check("rst_payload", o_axi_araddr, 0);
    i_ifu_arvalid = 0; i_ifu_araddr = 0; i_axi_arready = 0; i_axi_rvalid = 0; i_axi_bvalid = 0;
    i_lsu_awvalid = 0; i_axi_awready = 0;
    tick();
    i_reset = 1'b0;
    tick();

    // Single IFU read
    raise_ar(0, 32'h8000_0000, 4'h3, 8'd0);
    serve_read(0, 32'hDEAD_BEEF, RESP_OKAY, 1);

    // Simultaneous LSU/IFU reads; the winner re-requests for three rounds
    raise_ar(1, 32'h1000_0000, 4'h2, 8'd1);
    raise_ar(0, 32'h0000_1000, 4'h1, 8'd0);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      winner = !rr_last_lsu;
`else
      winner = 1'b1;
`endif
      serve_read(winner, 32'hA000_0000 + 32'(k * 16), (k == 2) ? RESP_SLVERR : RESP_OKAY,
                 int'(pend_len[winner]) + 1);
      if (k < 3) raise_ar(winner, 32'h2000_0000 + 32'(k * 64), 4'(k + 8), 8'(k % 2));
    end
    winner = i_lsu_arvalid;
    serve_read(winner, 32'hB000_0000, RESP_DECERR, int'(pend_len[winner]) + 1);

    // LSU store with a concurrent IFU request; write wins, W delayed two cycles
    raise_ar(0, 32'h8000_0200, 4'h6, 8'd0);
    i_lsu_awvalid = 1; i_lsu_awaddr = 32'h8000_0004; i_lsu_awid = 4'h7; i_lsu_awlen = 0;
    i_lsu_awsize = 3'd2; i_lsu_awburst = 2'b01;
    i_lsu_wvalid = 1; i_lsu_wdata = 32'hCAFE_0000; i_lsu_wstrb = 4'b1100; i_lsu_wlast = 1;
    check("aw_pre_grant", o_axi_awvalid, 0);
    tick();
    check("aw_latency", o_axi_awvalid, 1);
    check("ar_no_leak_wr", o_axi_arvalid, 0);
    wa.addr = 32'h8000_0004; wa.id = 4'h7; wa.len = 0; exp_aw.push_back(wa);
    ww.data = 32'hCAFE_0000; ww.strb = 4'b1100; ww.last = 1; exp_w.push_back(ww);
    i_axi_awready = 1;
    tick();
    i_axi_awready = 0;
    check("aw_masked", o_axi_awvalid, 0);
    check("w_forwarded", o_axi_wvalid, 1);
    tick();
    i_axi_wready = 1;
    tick();
    i_axi_wready = 0;
    check("w_masked", o_axi_wvalid, 0);
    i_lsu_awvalid = 0; i_lsu_wvalid = 0;
    i_axi_bvalid = 1; i_axi_bresp = RESP_OKAY; i_axi_bid = 4'h7;
    wb.resp = RESP_OKAY; wb.id = 4'h7; exp_b.push_back(wb);
    #1;
    check("bready_fwd", o_axi_bready, 1);
    tick();
    i_axi_bvalid = 0;
    check("wr_idle", dut.state, ST_IDLE);
    check("wr_flags_clr", {dut.aw_done, dut.w_done}, 2'b00);
    serve_read(0, 32'h0BAD_F00D, RESP_OKAY, 1);

    // Spurious downstream responses in IDLE
    i_axi_rvalid = 1; i_axi_rlast = 1; i_axi_rdata = 32'h5555_AAAA; i_axi_bvalid = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("spur_readies", {o_axi_rready, o_axi_bready}, 2'b00);
      check("spur_upstream", {o_ifu_rvalid, o_lsu_rvalid, o_lsu_bvalid}, 3'b000);
      tick();
    end
    i_axi_rvalid = 0; i_axi_rlast = 0; i_axi_bvalid = 0;
    check("spur_idle", dut.state, ST_IDLE);
    tick();

    // Reset in the middle of a 4-beat IFU burst
    raise_ar(0, 32'h8000_0100, 4'h5, 8'd3);
    serve_read(0, 32'h1111_0000, RESP_OKAY, 2);
    i_axi_rvalid = 1; i_axi_rdata = 32'h1111_0002; i_axi_rid = 4'h5; i_axi_rlast = 0;
    #1;
    check("pre_rst_rready", o_axi_rready, 1);
    i_reset = 1'b1;
    #1;
    check("midrst_state", dut.state, ST_IDLE);
    check("midrst_outs", {o_axi_rready, o_ifu_rvalid, o_axi_arvalid, o_ifu_arready, o_lsu_rvalid}, 5'b0);
    i_axi_rvalid = 0;
    rr_last_lsu = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    raise_ar(0, 32'h8000_0300, 4'h9, 8'd1);
    serve_read(0, 32'h2222_0000, RESP_OKAY, 2);

    tick(); tick();
    check("ar_queue_empty", exp_ar.size(), 0);
    check("ifu_r_queue_empty", exp_ifu_r.size(), 0);
    check("lsu_r_queue_empty", exp_lsu_r.size(), 0);
    check("aw_w_b_queues_empty", exp_aw.size() + exp_w.size() + exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
